// File: rtl/reg_bank32_fill.sv
// reg_bank32_fill
//   Bank of 32 x 32-bit registers loadable either one word at a time or by a
//   32-word ready/valid burst. Register contents are exported directly on
//   outR0..outR31 to feed a downstream 32:1 select mux.
//
//   Ports
//     clk        : clock, all state updates on the rising edge
//     reset      : synchronous active-high reset
//     wr_en      : single-word write strobe (honoured in IDLE and DONE only)
//     wr_addr    : single-word write index 0..31
//     wr_data    : single-word write data
//     fill_start : request to begin a 32-word burst fill
//     fill_valid : upstream holds a burst word on fill_data
//     fill_data  : burst word
//     fill_ready : block is accepting burst words
//     fill_busy  : burst in progress
//     fill_done  : one-cycle pulse when the burst completes
//     outR0..31  : register contents
//
//   Optional feature (macro REG_BANK32_VALID_EN):
//     inval_all  : clears all per-register valid bits
//     reg_valid  : per-register valid bits, set by any write to that register
module reg_bank32_fill #(
    parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [4:0]  wr_addr,
    input  logic [31:0] wr_data,
    input  logic        fill_start,
    input  logic        fill_valid,
    input  logic [31:0] fill_data,
    output logic        fill_ready,
    output logic        fill_busy,
    output logic        fill_done,
    output logic [31:0] outR0,
    output logic [31:0] outR1,
    output logic [31:0] outR2,
    output logic [31:0] outR3,
    output logic [31:0] outR4,
    output logic [31:0] outR5,
    output logic [31:0] outR6,
    output logic [31:0] outR7,
    output logic [31:0] outR8,
    output logic [31:0] outR9,
    output logic [31:0] outR10,
    output logic [31:0] outR11,
    output logic [31:0] outR12,
    output logic [31:0] outR13,
    output logic [31:0] outR14,
    output logic [31:0] outR15,
    output logic [31:0] outR16,
    output logic [31:0] outR17,
    output logic [31:0] outR18,
    output logic [31:0] outR19,
    output logic [31:0] outR20,
    output logic [31:0] outR21,
    output logic [31:0] outR22,
    output logic [31:0] outR23,
    output logic [31:0] outR24,
    output logic [31:0] outR25,
    output logic [31:0] outR26,
    output logic [31:0] outR27,
    output logic [31:0] outR28,
    output logic [31:0] outR29,
    output logic [31:0] outR30,
    output logic [31:0] outR31
`ifdef REG_BANK32_VALID_EN
    ,
    input  logic        inval_all,
    output logic [31:0] reg_valid
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [4:0]  r_cnt;
    logic        w_cnt_clr;
    logic        w_cnt_inc;
    logic [31:0] r_regs [32];

    // Single merged write port: burst and single-word writes are mutually
    // exclusive by FSM state, so one address/data mux feeds the bank.
    logic        w_we;
    logic [4:0]  w_waddr;
    logic [31:0] w_wdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        fill_ready  = 1'b0;
        fill_busy   = 1'b0;
        fill_done   = 1'b0;
        w_cnt_clr   = 1'b0;
        w_cnt_inc   = 1'b0;
        w_we        = 1'b0;
        w_waddr     = wr_addr;
        w_wdata     = wr_data;
        case (r_state)
            S_IDLE: begin
                w_we = wr_en;
                if (fill_start) begin
                    w_state_nxt = S_FILL;
                    w_cnt_clr   = 1'b1;
                end
            end
            S_FILL: begin
                fill_ready = 1'b1;
                fill_busy  = 1'b1;
                if (fill_valid) begin
                    w_we      = 1'b1;
                    w_waddr   = r_cnt;
                    w_wdata   = fill_data;
                    w_cnt_inc = 1'b1;
                    if (r_cnt == 5'd31) begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                fill_done   = 1'b1;
                w_we        = wr_en;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // The 5-bit counter wraps from 31 to 0 on the final handshake.
    always_ff @(posedge clk) begin
        if (reset || w_cnt_clr) begin
            r_cnt <= '0;
        end else if (w_cnt_inc) begin
            r_cnt <= r_cnt + 5'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < 32; i++) begin
                r_regs[i] <= RESET_VAL;
            end
        end else if (w_we) begin
            r_regs[w_waddr] <= w_wdata;
        end
    end

`ifdef REG_BANK32_VALID_EN
    logic [31:0] r_valid;

    // A write in the same cycle as inval_all survives the invalidate.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= '0;
        end else begin
            r_valid <= (inval_all ? '0 : r_valid)
                     | (w_we ? (32'h1 << w_waddr) : '0);
        end
    end

    assign reg_valid = r_valid;
`endif

    assign outR0  = r_regs[0];
    assign outR1  = r_regs[1];
    assign outR2  = r_regs[2];
    assign outR3  = r_regs[3];
    assign outR4  = r_regs[4];
    assign outR5  = r_regs[5];
    assign outR6  = r_regs[6];
    assign outR7  = r_regs[7];
    assign outR8  = r_regs[8];
    assign outR9  = r_regs[9];
    assign outR10 = r_regs[10];
    assign outR11 = r_regs[11];
    assign outR12 = r_regs[12];
    assign outR13 = r_regs[13];
    assign outR14 = r_regs[14];
    assign outR15 = r_regs[15];
    assign outR16 = r_regs[16];
    assign outR17 = r_regs[17];
    assign outR18 = r_regs[18];
    assign outR19 = r_regs[19];
    assign outR20 = r_regs[20];
    assign outR21 = r_regs[21];
    assign outR22 = r_regs[22];
    assign outR23 = r_regs[23];
    assign outR24 = r_regs[24];
    assign outR25 = r_regs[25];
    assign outR26 = r_regs[26];
    assign outR27 = r_regs[27];
    assign outR28 = r_regs[28];
    assign outR29 = r_regs[29];
    assign outR30 = r_regs[30];
    assign outR31 = r_regs[31];

endmodule
